// File: rtl/raster_pkg.sv
// Shared types for the raster walker: FSM/direction encodings and latched frame config.
package raster_pkg;

  // Strides are carried at this width internally so one config type serves any grid size.
  localparam int STRIDE_BITS = 16;

  typedef enum logic {IDLE, RUN} walk_state_e;
  typedef enum logic {DIR_POS, DIR_NEG} walk_dir_e;

  typedef struct packed {
    logic                   serpentine;
    logic                   continuous;
    logic [STRIDE_BITS-1:0] dx;
    logic [STRIDE_BITS-1:0] dy;
  } walk_cfg_t;

  // A zero stride would never advance; it is promoted to 1.
  function automatic logic [STRIDE_BITS-1:0] nz_stride(input logic [STRIDE_BITS-1:0] s);
    return (s == '0) ? STRIDE_BITS'(1) : s;
  endfunction

endpackage

// File: rtl/raster_walker_if.sv
// Coordinate stream interface: valid/ready handshake plus position and frame markers.
interface raster_walker_if #(
  parameter int XBITS = 10,
  parameter int YBITS = 9
);
  logic             out_valid;
  logic             out_ready;
  logic [XBITS-1:0] out_x;
  logic [YBITS-1:0] out_y;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  modport master (
    output out_valid, out_x, out_y, out_sof, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_sof, out_eol, out_eof,
    output out_ready
  );
endinterface

// File: rtl/axis_stepper.sv
// One axis of the walk: advance a position by a stride in either direction and flag
// when the step would leave the [0, LIMIT) range (the current position is the last).
module axis_stepper
  import raster_pkg::*;
#(
  parameter int BITS  = 10,
  parameter int LIMIT = 640
) (
  input  logic [BITS-1:0]        pos,
  input  logic [STRIDE_BITS-1:0] stride,
  input  walk_dir_e              dir,
  output logic [BITS-1:0]        next,
  output logic                   wrap
);

  localparam logic [STRIDE_BITS:0] LIM = (STRIDE_BITS+1)'(LIMIT);

  logic [STRIDE_BITS:0] sum;
  logic [BITS-1:0]      diff;

  // Forward step uses one extra bit so an overshoot past LIMIT is never lost to overflow.
  always_comb begin
    sum  = {1'b0, STRIDE_BITS'(pos)} + {1'b0, stride};
    diff = pos - BITS'(stride);
    if (dir == DIR_POS) begin
      wrap = (sum >= LIM);
      next = BITS'(sum);
    end else begin
      wrap = (STRIDE_BITS'(pos) < stride);
      next = diff;
    end
  end

endmodule

// File: rtl/raster_walker.sv
// 2-D coordinate generator: walks a WIDTH x HEIGHT grid with run-time strides,
// raster or serpentine order, single-shot or continuous frames, with backpressure.
module raster_walker
  import raster_pkg::*;
#(
  parameter int  WIDTH  = 640,
  parameter int  HEIGHT = 480,
  parameter int  FBITS  = 16,
  localparam int XBITS  = $clog2(WIDTH),
  localparam int YBITS  = $clog2(HEIGHT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             serpentine,
  input  logic             continuous,
  input  logic [XBITS-1:0] dx,
  input  logic [YBITS-1:0] dy,
  raster_walker_if.master  out,
  output logic             busy,
  output logic [FBITS-1:0] frame_count
);

  walk_state_e      state;
  walk_dir_e        dir;
  walk_cfg_t        cfg;
  logic [XBITS-1:0] x;
  logic [YBITS-1:0] y;
  logic             valid;
  logic             sof;

  logic [XBITS-1:0] x_next;
  logic [YBITS-1:0] y_next;
  logic             row_end;
  logic             frame_end;
  logic             beat;

  axis_stepper #(.BITS(XBITS), .LIMIT(WIDTH)) u_x_step (
    .pos    (x),
    .stride (cfg.dx),
    .dir    (dir),
    .next   (x_next),
    .wrap   (row_end)
  );

  axis_stepper #(.BITS(YBITS), .LIMIT(HEIGHT)) u_y_step (
    .pos    (y),
    .stride (cfg.dy),
    .dir    (DIR_POS),
    .next   (y_next),
    .wrap   (frame_end)
  );

  assign beat = valid & out.out_ready;

  // Row/frame markers depend only on registered position, so they hold steady under stall.
  assign out.out_valid = valid;
  assign out.out_x     = x;
  assign out.out_y     = y;
  assign out.out_sof   = sof;
  assign out.out_eol   = valid & row_end;
  assign out.out_eof   = valid & row_end & frame_end;
  assign busy          = (state == RUN);

  // Walk FSM: latch config on start, advance one coordinate per accepted beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dir         <= DIR_POS;
      cfg         <= '0;
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      sof         <= 1'b0;
      frame_count <= '0;
    end else if (abort) begin
      state <= IDLE;
      valid <= 1'b0;
      sof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg.serpentine <= serpentine;
            cfg.continuous <= continuous;
            cfg.dx         <= nz_stride(STRIDE_BITS'(dx));
            cfg.dy         <= nz_stride(STRIDE_BITS'(dy));
            x              <= '0;
            y              <= '0;
            dir            <= DIR_POS;
            valid          <= 1'b1;
            sof            <= 1'b1;
            state          <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            sof <= 1'b0;
            if (row_end) begin
              if (frame_end) begin
                frame_count <= frame_count + 1'b1;
                if (cfg.continuous) begin
                  // Restart reuses the latched strides/modes; inputs are not re-sampled.
                  x   <= '0;
                  y   <= '0;
                  dir <= DIR_POS;
                  sof <= 1'b1;
                end else begin
                  state <= IDLE;
                  valid <= 1'b0;
                end
              end else begin
                y <= y_next;
                if (cfg.serpentine) begin
                  // Serpentine keeps x and reverses, so the next row retraces this one.
                  dir <= (dir == DIR_POS) ? DIR_NEG : DIR_POS;
                end else begin
                  x <= '0;
                end
              end
            end else begin
              x <= x_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
